// File: rtl/vpm_seq_pkg.sv
// Shared types and constants for the variable-precision multiplier sequencer.
// Holds the FSM state encoding, Mode encodings, datapath widths and shift amounts.
// Optional build macro used by the sequencer: VPM_SEQ_PIPE_EN (adds product register).
package vpm_seq_pkg;

    localparam int OPW   = 16;  // operand width
    localparam int EXTW  = 9;   // extended byte width
    localparam int PRODW = 18;  // partial product width
    localparam int RESW  = 32;  // result width

    localparam logic MODE_8  = 1'b0;
    localparam logic MODE_16 = 1'b1;

    // Left shift applied to each partial product before accumulation
    localparam logic [4:0] SHIFT_P0 = 5'd0;
    localparam logic [4:0] SHIFT_P1 = 5'd8;
    localparam logic [4:0] SHIFT_P2 = 5'd8;
    localparam logic [4:0] SHIFT_P3 = 5'd16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        PD   = 3'd5,
        DONE = 3'd6
    } state_t;

    // Extend one byte to 9 bits; only sign-carrying bytes of signed operands get sign fill
    function automatic logic [EXTW-1:0] ext_byte(input logic [7:0] b, input logic sign_carry);
        return {sign_carry & b[7], b};
    endfunction

endpackage

// File: rtl/mul9x9_signed.sv
// Combinational 9x9 signed multiplier producing an 18-bit signed product.
// Zero latency; purely combinational, no handshake.
// Shared by all partial-product steps of the sequencer.
module mul9x9_signed
    import vpm_seq_pkg::*;
(
    input  logic signed [EXTW-1:0]  a,
    input  logic signed [EXTW-1:0]  b,
    output logic signed [PRODW-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/vpm_sequencer.sv
// Sequencer for the variable-precision multiplier: 8x8 or 16x16, signed or unsigned,
// built from byte partial products on one 9x9 signed multiplier.
// Latency 1 (8-bit) / 4 (16-bit) cycles after accept; 2 / 5 with VPM_SEQ_PIPE_EN.
// Backpressure: result held in DONE until out_ready; no new accept until back in IDLE.
module vpm_sequencer
    import vpm_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  A,
    input  logic [OPW-1:0]  B,
    input  logic            Signed,
    input  logic            Mode,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [RESW-1:0] P,
    output logic            out_valid,
    input  logic            out_ready
);

`ifdef VPM_SEQ_PIPE_EN
    localparam state_t LAST_STATE = PD;
`else
    localparam state_t LAST_STATE = DONE;
`endif

    state_t            state;
    logic [OPW-1:0]    a_q;
    logic [OPW-1:0]    b_q;
    logic              signed_q;
    logic              mode_q;
    logic [RESW-1:0]   acc;
    logic              out_valid_q;

    logic [7:0]        a_byte;
    logic [7:0]        b_byte;
    logic              a_hi;
    logic              b_hi;
    logic [4:0]        shift;
    logic [EXTW-1:0]   a_ext;
    logic [EXTW-1:0]   b_ext;
    logic [PRODW-1:0]  prod;
    logic [RESW-1:0]   pp;

`ifdef VPM_SEQ_PIPE_EN
    logic [RESW-1:0]   prod_q;
    logic              prod_vld;
`endif

    // Byte select and shift per compute state; in 8-bit mode the low bytes carry the sign
    always_comb begin
        a_byte = a_q[7:0];
        b_byte = b_q[7:0];
        a_hi   = 1'b0;
        b_hi   = 1'b0;
        shift  = SHIFT_P0;
        case (state)
            P1: begin
                b_byte = b_q[15:8];
                b_hi   = 1'b1;
                shift  = SHIFT_P1;
            end
            P2: begin
                a_byte = a_q[15:8];
                a_hi   = 1'b1;
                shift  = SHIFT_P2;
            end
            P3: begin
                a_byte = a_q[15:8];
                b_byte = b_q[15:8];
                a_hi   = 1'b1;
                b_hi   = 1'b1;
                shift  = SHIFT_P3;
            end
            default: ;
        endcase
        if (mode_q == MODE_8) begin
            a_hi = 1'b1;
            b_hi = 1'b1;
        end
    end

    assign a_ext = ext_byte(a_byte, signed_q & a_hi);
    assign b_ext = ext_byte(b_byte, signed_q & b_hi);

    mul9x9_signed u_mul (
        .a (a_ext),
        .b (b_ext),
        .p (prod)
    );

    // Sign-extend the partial product to result width and align it
    assign pp = {{(RESW-PRODW){prod[PRODW-1]}}, prod} << shift;

    // Handshake FSM, operand latch and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            mode_q      <= MODE_8;
            acc         <= '0;
            out_valid_q <= 1'b0;
`ifdef VPM_SEQ_PIPE_EN
            prod_q      <= '0;
            prod_vld    <= 1'b0;
`endif
        end else begin
`ifdef VPM_SEQ_PIPE_EN
            // Registered product lands in the accumulator one cycle after it was formed
            prod_vld <= 1'b0;
            if (prod_vld) begin
                acc <= acc + prod_q;
            end
`endif
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        signed_q <= Signed;
                        mode_q   <= Mode;
                        acc      <= '0;
                        state    <= P0;
                    end
                end
                P0, P1, P2, P3: begin
`ifdef VPM_SEQ_PIPE_EN
                    prod_q   <= pp;
                    prod_vld <= 1'b1;
`else
                    acc      <= acc + pp;
`endif
                    if (state == P3 || mode_q == MODE_8) begin
                        state       <= LAST_STATE;
                        out_valid_q <= (LAST_STATE == DONE);
                    end else if (state == P0) begin
                        state <= P1;
                    end else if (state == P1) begin
                        state <= P2;
                    end else begin
                        state <= P3;
                    end
                end
                PD: begin
                    state       <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready is a pure state decode, masked so it reads 0 while reset is held
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign P         = acc;

endmodule
